// File: rtl/result_readback_checker_if.sv
// Read-side Avalon-MM bundle for the result and golden RAM slave ports.
// The checker is the master; the two RAMs (or their models) are the slave.
interface result_readback_checker_if #(
    parameter int unsigned ADDR_WIDTH = 5
) ();
    logic                  res_read;
    logic [ADDR_WIDTH-1:0] res_address;
    logic [31:0]           res_readdata;
    logic                  gold_read;
    logic [ADDR_WIDTH-1:0] gold_address;
    logic [31:0]           gold_readdata;

    modport master (
        output res_read, res_address, gold_read, gold_address,
        input  res_readdata, gold_readdata
    );

    modport slave (
        input  res_read, res_address, gold_read, gold_address,
        output res_readdata, gold_readdata
    );
endinterface

// File: rtl/result_readback_checker.sv
// Reads a window of result RAM words and compares each against the golden RAM
// at the same address, reporting mismatch count and first failing address.
module result_readback_checker #(
    parameter int unsigned ADDR_WIDTH   = 5,
    parameter int unsigned BASE_ADDR    = 0,
    parameter int unsigned NUM_WORDS    = 32,
    parameter int unsigned READ_LATENCY = 1,
    parameter logic [31:0] DATA_MASK    = 32'hFFFF_FFFF
) (
    input  logic                    avalon_clock,
    input  logic                    resetn,
    input  logic                    start,
    input  logic                    abort,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [ADDR_WIDTH:0]     err_count,
    output logic                    first_err_valid,
    output logic [ADDR_WIDTH-1:0]   first_err_addr,
    result_readback_checker_if.master bus
);

    typedef enum logic [1:0] {StIdle, StRd, StWt, StDn} state_e;

    localparam int unsigned WaitW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [WaitW-1:0]      WaitLast  = WaitW'(READ_LATENCY - 1);
    localparam logic [ADDR_WIDTH-1:0] AddrFirst = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] AddrLast  = ADDR_WIDTH'(BASE_ADDR + NUM_WORDS - 1);

    state_e                r_state, w_state_next;
    logic [ADDR_WIDTH-1:0] r_addr, w_addr_next;
    logic [WaitW-1:0]      r_wait, w_wait_next;
    logic [ADDR_WIDTH:0]   r_err_count, w_err_next;
    logic                  r_first_valid, w_first_valid_next;
    logic [ADDR_WIDTH-1:0] r_first_addr, w_first_addr_next;
    logic                  r_done, w_done_next;
    logic                  r_pass, w_pass_next;
    logic                  r_busy;
    logic                  r_read;
    logic                  w_mismatch;

    assign w_mismatch = |((bus.res_readdata ^ bus.gold_readdata) & DATA_MASK);

    always_ff @(posedge avalon_clock or negedge resetn) begin
        if (!resetn) begin
            r_state       <= StIdle;
            r_addr        <= '0;
            r_wait        <= '0;
            r_err_count   <= '0;
            r_first_valid <= 1'b0;
            r_first_addr  <= '0;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_busy        <= 1'b0;
            r_read        <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_addr        <= w_addr_next;
            r_wait        <= w_wait_next;
            r_err_count   <= w_err_next;
            r_first_valid <= w_first_valid_next;
            r_first_addr  <= w_first_addr_next;
            r_done        <= w_done_next;
            r_pass        <= w_pass_next;
            // Status and strobes are registered off the next state so they align with it.
            r_busy        <= (w_state_next != StIdle);
            r_read        <= (w_state_next == StRd);
        end
    end

    always_comb begin
        w_state_next       = r_state;
        w_addr_next        = r_addr;
        w_wait_next        = r_wait;
        w_err_next         = r_err_count;
        w_first_valid_next = r_first_valid;
        w_first_addr_next  = r_first_addr;
        w_done_next        = r_done;
        w_pass_next        = r_pass;

        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_state_next       = StRd;
                    w_addr_next        = AddrFirst;
                    w_err_next         = '0;
                    w_first_valid_next = 1'b0;
                    w_first_addr_next  = '0;
                    w_done_next        = 1'b0;
                    w_pass_next        = 1'b0;
                end
            end
            StRd: begin
                w_state_next = StWt;
                w_wait_next  = '0;
            end
            StWt: begin
                if (r_wait == WaitLast) begin
                    if (w_mismatch) begin
                        w_err_next = r_err_count + 1'b1;
                        if (!r_first_valid) begin
                            w_first_valid_next = 1'b1;
                            w_first_addr_next  = r_addr;
                        end
                    end
                    // Equality terminal test: a window ending at the top address never wraps.
                    if (r_addr == AddrLast) begin
                        w_state_next = StDn;
                    end else begin
                        w_addr_next  = r_addr + 1'b1;
                        w_state_next = StRd;
                    end
                end else begin
                    w_wait_next = r_wait + 1'b1;
                end
            end
            StDn: begin
                w_state_next = StIdle;
                w_done_next  = 1'b1;
                w_pass_next  = (r_err_count == '0);
            end
            default: w_state_next = StIdle;
        endcase

        // Abort drops the in-flight compare and leaves partial results visible.
        if (abort && (r_state != StIdle)) begin
            w_state_next       = StIdle;
            w_addr_next        = r_addr;
            w_err_next         = r_err_count;
            w_first_valid_next = r_first_valid;
            w_first_addr_next  = r_first_addr;
            w_done_next        = r_done;
            w_pass_next        = r_pass;
        end
    end

    assign busy             = r_busy;
    assign done             = r_done;
    assign pass             = r_pass;
    assign err_count        = r_err_count;
    assign first_err_valid  = r_first_valid;
    assign first_err_addr   = r_first_addr;
    assign bus.res_read     = r_read;
    assign bus.gold_read    = r_read;
    assign bus.res_address  = r_addr;
    assign bus.gold_address = r_addr;

endmodule

// File: tb/tb_result_readback_checker.sv
// Directed bench: default-parameter checker plus a masked, 2-cycle-latency,
// top-of-window instance, both fed from shared result/golden RAM models.
module tb_result_readback_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic resetn;
    logic start0, abort0, start1, abort1;
    logic busy0, done0, pass0, fv0;
    logic busy1, done1, pass1, fv1;
    logic [5:0] err0, err1;
    logic [4:0] fa0, fa1;

    int n_vec = 0;
    int n_mis = 0;
    int cyc = 0;

    result_readback_checker_if #(.ADDR_WIDTH(5)) bus0 ();
    result_readback_checker_if #(.ADDR_WIDTH(5)) bus1 ();

    result_readback_checker dut0 (
        .avalon_clock    (clk),
        .resetn          (resetn),
        .start           (start0),
        .abort           (abort0),
        .busy            (busy0),
        .done            (done0),
        .pass            (pass0),
        .err_count       (err0),
        .first_err_valid (fv0),
        .first_err_addr  (fa0),
        .bus             (bus0.master)
    );

    result_readback_checker #(
        .BASE_ADDR    (28),
        .NUM_WORDS    (4),
        .READ_LATENCY (2),
        .DATA_MASK    (32'h7FFF_FFFF)
    ) dut1 (
        .avalon_clock    (clk),
        .resetn          (resetn),
        .start           (start1),
        .abort           (abort1),
        .busy            (busy1),
        .done            (done1),
        .pass            (pass1),
        .err_count       (err1),
        .first_err_valid (fv1),
        .first_err_addr  (fa1),
        .bus             (bus1.master)
    );

    logic [31:0] res_mem [32];
    logic [31:0] gold_mem [32];

    always @(posedge clk) cyc <= cyc + 1;

    // 1-cycle slave; distinct filler on each bus exposes a wrong sampling cycle.
    always @(posedge clk) begin
        bus0.res_readdata  <= bus0.res_read  ? res_mem[bus0.res_address]   : 32'hDEAD_BEEF;
        bus0.gold_readdata <= bus0.gold_read ? gold_mem[bus0.gold_address] : 32'h0BAD_F00D;
    end

    // 2-cycle slave
    logic        p1_v = 1'b0;
    logic [31:0] p1_res, p1_gold;
    always @(posedge clk) begin
        p1_v               <= bus1.res_read;
        p1_res             <= res_mem[bus1.res_address];
        p1_gold            <= gold_mem[bus1.gold_address];
        bus1.res_readdata  <= p1_v ? p1_res  : 32'hDEAD_BEEF;
        bus1.gold_readdata <= p1_v ? p1_gold : 32'h0BAD_F00D;
    end

    int q0_addr[$], q0_gold[$], q0_cyc[$];
    int q1_addr[$], q1_cyc[$];
    int n0_gold_reads = 0;
    always @(posedge clk) begin
        if (bus0.res_read) begin
            q0_addr.push_back(int'(bus0.res_address));
            q0_gold.push_back(int'(bus0.gold_address));
            q0_cyc.push_back(cyc);
        end
        if (bus0.gold_read) n0_gold_reads <= n0_gold_reads + 1;
        if (bus1.res_read) begin
            q1_addr.push_back(int'(bus1.res_address));
            q1_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic mem_init();
        for (int a = 0; a < 32; a++) begin
            res_mem[a]  = 32'h1234_0000 + 32'(a);
            gold_mem[a] = 32'h1234_0000 + 32'(a);
        end
    endtask

    // Returns edges counted from the start-sampling edge until done (or abort edge).
    task automatic run0(input int restart_at, input int abort_at, output int n);
        q0_addr.delete(); q0_gold.delete(); q0_cyc.delete();
        n0_gold_reads = 0;
        @(negedge clk); start0 = 1'b1;
        @(posedge clk); #1; start0 = 1'b0;
        n = 0;
        chk("busy_after_start", busy0, 1);
        while (!done0 && n < 300) begin
            start0 = (n == restart_at);
            abort0 = (n == abort_at);
            @(posedge clk); #1; n++;
            start0 = 1'b0;
            if (abort0) begin
                abort0 = 1'b0;
                break;
            end
        end
    endtask

    task automatic run1(output int n);
        q1_addr.delete(); q1_cyc.delete();
        @(negedge clk); start1 = 1'b1;
        @(posedge clk); #1; start1 = 1'b0;
        n = 0;
        while (!done1 && n < 300) begin
            @(posedge clk); #1; n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int n;
        resetn = 1'b0;
        start0 = 1'b0; abort0 = 1'b0; start1 = 1'b0; abort1 = 1'b0;
        mem_init();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_pass", pass0, 0);
        chk("rst_err", err0, 0);
        chk("rst_fv", fv0, 0);
        chk("rst_fa", fa0, 0);
        chk("rst_res_read", bus0.res_read, 0);
        chk("rst_gold_read", bus0.gold_read, 0);
        chk("rst_res_addr", bus0.res_address, 0);
        chk("rst_gold_addr", bus0.gold_address, 0);
        chk("rst_busy1", busy1, 0);
        @(negedge clk); resetn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_no_read", q0_addr.size(), 0);

        // All words match; extra start at cycle 10 must be ignored.
        run0(10, -1, n);
        chk("match_latency", n, 65);
        chk("match_done", done0, 1);
        chk("match_pass", pass0, 1);
        chk("match_err", err0, 0);
        chk("match_fv", fv0, 0);
        chk("match_busy_fall", busy0, 0);
        chk("match_nreads", q0_addr.size(), 32);
        chk("match_ngold", n0_gold_reads, 32);
        for (int i = 0; i < q0_addr.size() && i < 32; i++) begin
            chk($sformatf("match_addr%0d", i), q0_addr[i], i);
            chk($sformatf("match_gaddr%0d", i), q0_gold[i], i);
            if (i > 0) chk($sformatf("match_gap%0d", i), q0_cyc[i] - q0_cyc[i-1], 2);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("done_held", done0, 1);
        chk("pass_held", pass0, 1);

        // Mismatches at words 5 and 20
        res_mem[5]  = res_mem[5]  ^ 32'h1;
        res_mem[20] = res_mem[20] ^ 32'h1;
        run0(-1, -1, n);
        chk("mm_latency", n, 65);
        chk("mm_done", done0, 1);
        chk("mm_err", err0, 2);
        chk("mm_fa", fa0, 5);
        chk("mm_fv", fv0, 1);
        chk("mm_pass", pass0, 0);

        // Abort in WT of word 10 (cycle 21) after a mismatch at word 3
        mem_init();
        res_mem[3] = res_mem[3] ^ 32'h1;
        run0(-1, 21, n);
        chk("ab_edge", n, 22);
        chk("ab_busy", busy0, 0);
        chk("ab_done", done0, 0);
        chk("ab_pass", pass0, 0);
        chk("ab_err", err0, 1);
        chk("ab_fa", fa0, 3);
        chk("ab_fv", fv0, 1);
        chk("ab_nreads", q0_addr.size(), 11);
        repeat (4) @(posedge clk);
        #1;
        chk("ab_quiet", q0_addr.size(), 11);
        chk("ab_done_stays", done0, 0);
        mem_init();
        run0(-1, -1, n);
        chk("rerun_latency", n, 65);
        chk("rerun_pass", pass0, 1);
        chk("rerun_err", err0, 0);
        chk("rerun_fv", fv0, 0);

        // Masked 2-cycle-latency window 28..31: bit 31 differences ignored
        mem_init();
        for (int a = 28; a < 32; a++) res_mem[a] = res_mem[a] ^ 32'h8000_0000;
        run1(n);
        chk("w1_latency", n, 13);
        chk("w1_pass", pass1, 1);
        chk("w1_err", err1, 0);
        chk("w1_busy_fall", busy1, 0);
        chk("w1_nreads", q1_addr.size(), 4);
        for (int i = 0; i < q1_addr.size() && i < 4; i++) begin
            chk($sformatf("w1_addr%0d", i), q1_addr[i], 28 + i);
            if (i > 0) chk($sformatf("w1_gap%0d", i), q1_cyc[i] - q1_cyc[i-1], 3);
        end
        chk("w1_idle0", busy0, 0);
        res_mem[31] = res_mem[31] ^ 32'h4000_0000;
        run1(n);
        chk("w1b_latency", n, 13);
        chk("w1b_err", err1, 1);
        chk("w1b_fa", fa1, 31);
        chk("w1b_fv", fv1, 1);
        chk("w1b_pass", pass1, 0);

        // Asynchronous reset in WT of word 1, after word 0 mismatched
        mem_init();
        res_mem[0] = res_mem[0] ^ 32'h1;
        @(negedge clk); start0 = 1'b1;
        @(posedge clk); #1; start0 = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("pre_rst_err", err0, 1);
        chk("pre_rst_addr", bus0.res_address, 1);
        resetn = 1'b0;
        #1;
        chk("arst_busy", busy0, 0);
        chk("arst_err", err0, 0);
        chk("arst_fv", fv0, 0);
        chk("arst_addr", bus0.res_address, 0);
        chk("arst_read", bus0.res_read, 0);
        chk("arst_done1", done1, 0);
        q0_addr.delete();
        repeat (4) @(posedge clk);
        @(negedge clk); resetn = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("arst_no_reads", q0_addr.size(), 0);
        chk("arst_still_idle", busy0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
